// File: rtl/pcm_frame_pkg.sv
// -----------------------------------------------------------------------------
// pcm_frame_pkg
// Shared definitions for the framed PCM receiver: state encoding, default
// sync bytes and the frame header length.
// -----------------------------------------------------------------------------
package pcm_frame_pkg;

  // Default sync word, sent as SYNC0 then SYNC1.
  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

  // Header bytes preceding the payload: SYNC0, SYNC1, N.
  localparam int HDR_LEN = 3;

  // State encodings.
  localparam logic [2:0] ST_HUNT0 = 3'd0;
  localparam logic [2:0] ST_HUNT1 = 3'd1;
  localparam logic [2:0] ST_LEN   = 3'd2;
  localparam logic [2:0] ST_LEFT  = 3'd3;
  localparam logic [2:0] ST_RIGHT = 3'd4;
  localparam logic [2:0] ST_CSUM  = 3'd5;

  typedef enum logic [2:0] {
    HUNT0 = ST_HUNT0,
    HUNT1 = ST_HUNT1,
    LEN   = ST_LEN,
    LEFT  = ST_LEFT,
    RIGHT = ST_RIGHT,
    CSUM  = ST_CSUM
  } state_e;

endpackage

// File: rtl/pcm_frame_timeout.sv
// -----------------------------------------------------------------------------
// pcm_frame_timeout
// Idle-cycle watchdog for the frame receiver.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : a byte arrived this cycle; restart the idle count
//   run          : receiver is inside a frame (not hunting for SYNC0)
//   expired      : abort the frame at this clock edge
// -----------------------------------------------------------------------------
module pcm_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 1200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  // The byte's own cycle is cycle 0 and the receiver registers its error
  // flag, so the abort must be taken at the edge closing idle cycle
  // TIMEOUT_CYCLES-1; that is where the count has reached TIMEOUT_CYCLES-2.
  localparam logic [CW-1:0] FIRE_AT = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // A byte in the same cycle always wins over the timeout.
  assign expired = run && !clear && (cnt == FIRE_AT);

endmodule

// File: rtl/pcm_frame_rx.sv
// -----------------------------------------------------------------------------
// pcm_frame_rx
// Framed PCM receiver: SYNC0 SYNC1 N {L R}xN C, with C = XOR of N and all
// sample bytes. Each L/R pair is streamed to the sample FIFO as {L, R}.
//   clk, reset_n          : clock, asynchronous active-low reset
//   rx_data, rx_valid     : UART byte and its one-cycle strobe
//   fifo_full             : sample FIFO cannot accept a word
//   wr_en, wr_data        : FIFO write strobe and {L, R} word
//   frame_ok, frame_err   : one-cycle frame result pulses
//   err_count, drop_count : saturating error / dropped-sample counters
//   busy                  : receiver is inside a frame
// -----------------------------------------------------------------------------
module pcm_frame_rx
  import pcm_frame_pkg::*;
#(
  parameter logic [7:0] SYNC0          = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1          = SYNC1_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        fifo_full,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic [7:0]  drop_count,
  output logic        busy
);

  state_e     state;
  logic [7:0] remaining;
  logic [7:0] csum;
  logic [7:0] left_buf;
  logic       tmo_expired;

  pcm_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (rx_valid),
    .run     (busy),
    .expired (tmo_expired)
  );

  // busy is registered alongside state and always updated with it, so it
  // is exactly (state != HUNT0) without a decode after the flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HUNT0;
      remaining  <= '0;
      csum       <= '0;
      left_buf   <= '0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
      drop_count <= '0;
      busy       <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (rx_valid) begin
        case (state)
          HUNT0: begin
            if (rx_data == SYNC0) begin
              state <= HUNT1;
              busy  <= 1'b1;
            end
          end

          HUNT1: begin
            if (rx_data == SYNC1) begin
              state <= LEN;
            end else if (rx_data != SYNC0) begin
              // A repeated SYNC0 may be the true start; anything else is noise.
              state <= HUNT0;
              busy  <= 1'b0;
            end
          end

          LEN: begin
            if (rx_data == 8'd0) begin
              frame_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              state <= HUNT0;
              busy  <= 1'b0;
            end else begin
              remaining <= rx_data;
              csum      <= rx_data;
              state     <= LEFT;
            end
          end

          LEFT: begin
            left_buf <= rx_data;
            csum     <= csum ^ rx_data;
            state    <= RIGHT;
          end

          RIGHT: begin
            csum <= csum ^ rx_data;
            if (fifo_full) begin
              if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end else begin
              wr_en   <= 1'b1;
              wr_data <= {left_buf, rx_data};
            end
            remaining <= remaining - 8'd1;
            state     <= (remaining == 8'd1) ? CSUM : LEFT;
          end

          CSUM: begin
            if (rx_data == csum) begin
              frame_ok <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            state <= HUNT0;
            busy  <= 1'b0;
          end

          default: begin
            state <= HUNT0;
            busy  <= 1'b0;
          end
        endcase
      end else if (tmo_expired) begin
        frame_err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        left_buf <= '0;
        state    <= HUNT0;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcm_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_pcm_frame_rx
// Directed bench for pcm_frame_rx: good frame, bad checksum, resync, zero
// length, full FIFO, timeout and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_pcm_frame_rx;
  import pcm_frame_pkg::*;

  localparam int T = 1200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        fifo_full = 1'b0;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        frame_ok;
  logic        frame_err;
  logic [7:0]  err_count;
  logic [7:0]  drop_count;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int wr_seen = 0;

  logic [7:0] hdr [HDR_LEN];

  pcm_frame_rx #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fifo_full  (fifo_full),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .err_count  (err_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Counts write pulses; each pulse spans exactly one negedge.
  always @(negedge clk) if (reset_n && wr_en) wr_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte for one clock; returns 1 time unit after the edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_header(input logic [7:0] n);
    hdr[0] = 8'hA5;
    hdr[1] = 8'h5A;
    hdr[2] = n;
    for (int i = 0; i < HDR_LEN; i++) send(hdr[i]);
  endtask

  int w0;

  initial begin
    // ---- reset state ----
    #12;
    check("rst_wr_en",   32'(wr_en), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_ok_err",  {30'd0, frame_ok, frame_err}, 0);
    check("rst_counts",  {16'd0, err_count, drop_count}, 0);
    check("rst_busy",    32'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- good frame: A5 5A 02 10 20 30 40 42 ----
    w0 = wr_seen;
    send(8'hA5);
    check("good_busy_after_sync0", 32'(busy), 1);
    send(8'h5A); send(8'h02); send(8'h10); send(8'h20);
    check("good_w1_en",   32'(wr_en), 1);
    check("good_w1_data", 32'(wr_data), 32'h1020);
    send(8'h30); send(8'h40);
    check("good_w2_en",   32'(wr_en), 1);
    check("good_w2_data", 32'(wr_data), 32'h3040);
    send(8'h42);
    check("good_ok",  32'(frame_ok), 1);
    check("good_err", 32'(frame_err), 0);
    idle(1);
    check("good_ok_pulse_len", 32'(frame_ok), 0);
    check("good_busy_end",     32'(busy), 0);
    check("good_err_count",    32'(err_count), 0);
    check("good_writes",       32'(wr_seen - w0), 2);

    // ---- bad checksum: last byte 43 ----
    w0 = wr_seen;
    send_header(8'h02);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40); send(8'h43);
    check("badck_err", 32'(frame_err), 1);
    check("badck_ok",  32'(frame_ok), 0);
    idle(1);
    check("badck_err_pulse_len", 32'(frame_err), 0);
    check("badck_err_count",     32'(err_count), 1);
    check("badck_busy",          32'(busy), 0);
    check("badck_writes",        32'(wr_seen - w0), 2);

    // ---- resync: 00 A5 A5 5A 01 7F 80 FE ----
    w0 = wr_seen;
    send(8'h00);
    check("resync_noise_busy", 32'(busy), 0);
    send(8'hA5); send(8'hA5);
    check("resync_rep_sync0_busy", 32'(busy), 1);
    send(8'h5A); send(8'h01); send(8'h7F); send(8'h80);
    check("resync_wr_data", 32'(wr_data), 32'h7F80);
    send(8'hFE);
    check("resync_ok", 32'(frame_ok), 1);
    idle(1);
    check("resync_writes", 32'(wr_seen - w0), 1);

    // ---- zero length, then good frame ----
    send_header(8'h00);
    check("zlen_err", 32'(frame_err), 1);
    idle(1);
    check("zlen_err_count", 32'(err_count), 2);
    check("zlen_busy",      32'(busy), 0);
    send_header(8'h02);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40); send(8'h42);
    check("zlen_then_ok", 32'(frame_ok), 1);
    idle(1);
    check("zlen_then_err_count", 32'(err_count), 2);

    // ---- full FIFO on the second R byte ----
    w0 = wr_seen;
    send_header(8'h02);
    send(8'h10); send(8'h20);
    check("full_w1_data", 32'(wr_data), 32'h1020);
    send(8'h30);
    fifo_full = 1'b1;
    send(8'h40);
    fifo_full = 1'b0;
    check("full_w2_suppressed", 32'(wr_en), 0);
    check("full_drop_count",    32'(drop_count), 1);
    send(8'h42);
    check("full_ok", 32'(frame_ok), 1);
    idle(1);
    check("full_writes", 32'(wr_seen - w0), 1);

    // ---- timeout: A5 5A 02 10 then idle ----
    send_header(8'h02);
    send(8'h10);
    // The 10 byte's cycle ends at the edge just taken; the error must show
    // up in the cycle TIMEOUT_CYCLES later, i.e. after T-1 further edges.
    idle(T - 2);
    check("tmo_not_early_err",  32'(frame_err), 0);
    check("tmo_not_early_busy", 32'(busy), 1);
    idle(1);
    check("tmo_err",       32'(frame_err), 1);
    check("tmo_err_count", 32'(err_count), 3);
    idle(1);
    check("tmo_err_pulse_len", 32'(frame_err), 0);
    check("tmo_busy",          32'(busy), 0);

    // ---- asynchronous reset during the payload ----
    send_header(8'h02);
    send(8'h10); send(8'h20); send(8'h30);
    check("mid_busy_before_rst", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_wr_data", 32'(wr_data), 0);
    check("mid_rst_counts",  {16'd0, err_count, drop_count}, 0);
    check("mid_rst_flags",   {28'd0, wr_en, frame_ok, frame_err, busy}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    w0 = wr_seen;
    send_header(8'h02);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    check("post_rst_wr_data", 32'(wr_data), 32'h3040);
    send(8'h42);
    check("post_rst_ok", 32'(frame_ok), 1);
    idle(1);
    check("post_rst_writes",    32'(wr_seen - w0), 2);
    check("post_rst_err_count", 32'(err_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
